// File: rtl/alu_result_fifo.sv
// Result capture FIFO behind the 8-bit ALU: stores {zero, sign, ov, cout, z}.
// Define ALU_STICKY_FLAGS_EN to add sticky overflow/carry status.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_ov,
    input  logic             in_sign,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
`ifdef ALU_STICKY_FLAGS_EN
    output logic             sticky_ov,
    output logic             sticky_cout,
    input  logic             clr_sticky,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int AW = CNT_W - 1;
    localparam int EW = WIDTH + 4;

    logic [EW-1:0]    mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             zero;
    logic [EW-1:0]    head;

    // Extra wrap bit distinguishes full from empty when indexes match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign zero = (in_z == '0);

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = head[WIDTH-1:0];
    assign out_flags = head[EW-1:WIDTH];
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= {zero, in_sign, in_ov, in_cout, in_z};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
            unique case (1'b1)
                push && !pop: cnt_q <= cnt_q + CNT_W'(1);
                pop && !push: cnt_q <= cnt_q - CNT_W'(1);
                default:      cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Clear wins over a same-cycle accumulate.
    always_ff @(posedge clk) begin
        if (rst || clr_sticky) begin
            sticky_ov   <= 1'b0;
            sticky_cout <= 1'b0;
        end else if (push) begin
            sticky_ov   <= sticky_ov | in_ov;
            sticky_cout <= sticky_cout | in_cout;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo.
// Covers ALU_STICKY_FLAGS_EN when the macro is defined.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_z;
    logic       in_ov;
    logic       in_sign;
    logic       in_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic [2:0] count;
`ifdef ALU_STICKY_FLAGS_EN
    logic       sticky_ov;
    logic       sticky_cout;
    logic       clr_sticky;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_z(in_z),
        .in_ov(in_ov),
        .in_sign(in_sign),
        .in_cout(in_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_flags(out_flags),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_ov(sticky_ov),
        .sticky_cout(sticky_cout),
        .clr_sticky(clr_sticky),
`endif
        .count(count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_z      = 8'h00;
        in_ov     = 1'b0;
        in_sign   = 1'b0;
        in_cout   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif
        step();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL reset_count got %0d want 0", count);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_z     = 8'h09;
        step();
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h09) begin
            fails++;
            $display("FAIL basic_head got v=%b d=%h want v=1 d=09",
                     out_valid, out_data);
        end
        tests++;
        if (out_flags !== 4'b0000 || count !== 3'd1) begin
            fails++;
            $display("FAIL basic_flags got f=%b c=%0d want f=0000 c=1",
                     out_flags, count);
        end
        out_ready = 1'b1;
        step();
        idle();
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL basic_pop got v=%b c=%0d want v=0 c=0",
                     out_valid, count);
        end
    endtask

    task automatic test_flags();
        in_valid = 1'b1;
        in_z     = 8'h00;
        step();
        in_z     = 8'hFD;
        in_sign  = 1'b1;
        step();
        idle();
        tests++;
        if (out_data !== 8'h00 || out_flags !== 4'b1000) begin
            fails++;
            $display("FAIL zero_flag got d=%h f=%b want d=00 f=1000",
                     out_data, out_flags);
        end
        tests++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL flags_count got %0d want 2", count);
        end
        out_ready = 1'b1;
        step();
        idle();
        tests++;
        if (out_data !== 8'hFD || out_flags !== 4'b0100) begin
            fails++;
            $display("FAIL sign_flag got d=%h f=%b want d=fd f=0100",
                     out_data, out_flags);
        end
        out_ready = 1'b1;
        step();
        idle();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flags_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_z     = 8'(i);
            step();
        end
        idle();
        tests++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            fails++;
            $display("FAIL full_state got r=%b c=%0d want r=0 c=4",
                     in_ready, count);
        end
        tests++;
        if (out_data !== 8'h01) begin
            fails++;
            $display("FAIL full_hold got %h want 01", out_data);
        end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                fails++;
                $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, 8'(i));
            end
            out_ready = 1'b1;
            step();
        end
        idle();
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL full_drop got v=%b c=%0d want v=0 c=0",
                     out_valid, count);
        end
    endtask

    task automatic test_simul();
        logic [7:0] q[$];
        in_valid = 1'b1;
        in_z     = 8'hA0;
        step();
        in_z     = 8'hA1;
        step();
        q = '{8'hA0, 8'hA1};
        for (int k = 0; k < 6; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_z      = 8'h15 + 8'(k);
            tests++;
            if (out_data !== q[0]) begin
                fails++;
                $display("FAIL simul_head_%0d got %h want %h",
                         k, out_data, q[0]);
            end
            step();
            void'(q.pop_front());
            q.push_back(8'h15 + 8'(k));
            tests++;
            if (count !== 3'd2) begin
                fails++;
                $display("FAIL simul_count_%0d got %0d want 2", k, count);
            end
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (out_data !== q[k]) begin
                fails++;
                $display("FAIL simul_drain_%0d got %h want %h",
                         k, out_data, q[k]);
            end
            out_ready = 1'b1;
            step();
        end
        idle();
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL simul_end got %0d want 0", count);
        end
    endtask

`ifdef ALU_STICKY_FLAGS_EN
    task automatic test_sticky();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        in_valid   = 1'b1;
        in_z       = 8'h80;
        in_ov      = 1'b1;
        step();
        in_z       = 8'h15;
        in_ov      = 1'b0;
        step();
        idle();
        tests++;
        if (sticky_ov !== 1'b1 || sticky_cout !== 1'b0) begin
            fails++;
            $display("FAIL sticky_set got ov=%b c=%b want ov=1 c=0",
                     sticky_ov, sticky_cout);
        end
        clr_sticky = 1'b1;
        in_valid   = 1'b1;
        in_ov      = 1'b1;
        in_cout    = 1'b1;
        step();
        clr_sticky = 1'b0;
        idle();
        tests++;
        if (sticky_ov !== 1'b0 || sticky_cout !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clr got ov=%b c=%b want ov=0 c=0",
                     sticky_ov, sticky_cout);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cout   = 1'b1;
        step();
        idle();
        tests++;
        if (sticky_cout !== 1'b1 || sticky_ov !== 1'b0) begin
            fails++;
            $display("FAIL sticky_cout got ov=%b c=%b want ov=0 c=1",
                     sticky_ov, sticky_cout);
        end
    endtask
`endif

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_z     = 8'h30 + 8'(i);
            in_ov    = 1'b1;
            in_cout  = 1'b1;
            step();
        end
        idle();
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL mid_fill got %0d want 3", count);
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_z      = 8'h77;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        idle();
        tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst got c=%0d v=%b r=%b want c=0 v=0 r=1",
                     count, out_valid, in_ready);
        end
`ifdef ALU_STICKY_FLAGS_EN
        tests++;
        if (sticky_ov !== 1'b0 || sticky_cout !== 1'b0) begin
            fails++;
            $display("FAIL mid_sticky got ov=%b c=%b want 0 0",
                     sticky_ov, sticky_cout);
        end
`endif
        in_valid = 1'b1;
        in_z     = 8'h2A;
        step();
        in_z     = 8'h2B;
        step();
        idle();
        tests++;
        if (out_data !== 8'h2A || count !== 3'd2) begin
            fails++;
            $display("FAIL mid_first got d=%h c=%0d want d=2a c=2",
                     out_data, count);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_flags();
        test_full();
        test_simul();
`ifdef ALU_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Capture stage directly downstream of the 8-bit ALU.
- Registers each ALU result (z) with its flags (ov, sign, cout) plus a locally derived zero flag, and buffers them in a small FIFO.
- Hands results to the consumer over a valid/ready handshake, so ALU producer and consumer rates are decoupled.
- Optionally keeps sticky overflow/carry status across many operations.

Parameters:
- WIDTH, 8, result data width; matches the ALU z width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count and of the read/write pointers (one extra wrap bit).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result on in_z/in_ov/in_sign/in_cout is valid this cycle.
- in_ready  output  1  FIFO can accept an entry this cycle.
- in_z  input  WIDTH  ALU result.
- in_ov  input  1  ALU signed overflow.
- in_sign  input  1  ALU sign flag.
- in_cout  input  1  ALU carry out.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  WIDTH  head entry result.
- out_flags  output  4  head entry flags, {zero, sign, ov, cout}.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- sticky_ov  output  1  sticky overflow; only present with the optional feature.
- sticky_cout  output  1  sticky carry; only present with the optional feature.
- clr_sticky  input  1  clears the sticky flags; only present with the optional feature.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1.
  - sticky flags=0.
  - Memory contents are not cleared; out_data/out_flags are don't-care while out_valid=0.
- Reset asserted mid-operation discards all entries on that edge. Any push or pop presented in the same cycle is ignored.
- Entry format: {zero, sign, ov, cout, z}, 12 bits at default width. zero = (in_z == 0), computed at push time.
- Push: fires when in_valid && in_ready. The entry is written at mem[wr_ptr[CNT_W-2:0]] and wr_ptr increments.
- Pop: fires when out_valid && out_ready; rd_ptr increments.
- Handshake outputs:
  - in_ready = !full.
  - out_valid = !empty.
  - Both are derived from registered pointers only, with no combinational path from in_valid or out_ready.
- Status decode:
  - empty when wr_ptr == rd_ptr.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*DEPTH, so index wrap is DEPTH-1 -> 0.
- Latency: a push in cycle N appears on out_valid/out_data in cycle N+1. There is no same-cycle pass-through when empty.
- out_data/out_flags are driven combinationally from mem[rd_ptr] and hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - When neither empty nor full, both occur and count is unchanged.
  - When empty, only the push occurs (out_valid=0).
  - When full, only the pop occurs (in_ready=0). The freed slot becomes visible as in_ready=1 in the next cycle.
- Push attempted while full (in_valid=1, in_ready=0): data dropped by the FIFO. The producer must hold it.
- count updates: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- Flags pass through unmodified. No re-computation beyond the zero flag.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- Defined:
  - sticky_ov and sticky_cout ports and registers exist.
  - On every accepted push: sticky_ov <= sticky_ov | in_ov, and sticky_cout <= sticky_cout | in_cout.
  - clr_sticky=1 clears both on that edge; clear has priority over a same-cycle set.
  - rst clears both.
- Not defined: the ports, registers and clr_sticky input are absent. All other behaviour is identical.

Test Plan:
- Reset then push z=8'h09, ov=0, sign=0, cout=0 -> next cycle out_valid=1, out_data=8'h09, out_flags=4'b0000, count=1.
- Push z=8'h00 -> out_flags[3] (zero)=1. Push z=8'hFD, sign=1 -> out_flags=4'b0100.
- Hold out_ready=0 and push 5 results 8'h01..8'h05 -> in_ready=0 after the 4th push, count=4. Drain with out_ready=1 -> 8'h01..8'h04 in order; 8'h05 is absent.
- With count=2, assert push (8'h15) and pop in the same cycle -> count stays 2 and the head advances. Repeat across index wrap (7+ total pushes) -> order preserved.
- With ALU_STICKY_FLAGS_EN: push z=8'h80, ov=1, then z=8'h15, ov=0 -> sticky_ov stays 1. Assert clr_sticky together with a push that has ov=1 -> sticky_ov=0 the next cycle.
- With 3 entries buffered, assert rst for 1 cycle -> next cycle count=0, out_valid=0, in_ready=1. A subsequent push of 8'h2A is the first popped value.
